// File: rtl/prbs_chk_pkg.sv
// Shared types and constants for the 16-lane PRBS receive checker.
package prbs_chk_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 32;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [31:0]      DEFAULT_EQN = 32'h0010_0002;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_HUNT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

endpackage

// File: rtl/prbs_lane_checker.sv
// One self-synchronizing PRBS lane: received-bit history, tap predictor, mismatch.
module prbs_lane_checker
  import prbs_chk_pkg::*;
#(
  parameter int unsigned PRBS_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic              inv,
  input  logic [PRBS_W-1:0] eqn,
  input  logic              din,
  output logic              mismatch_c
);

  logic [PRBS_W-1:0] hist_q;
  logic              d_c;
  logic              pred_c;

  // Received bit after polarity correction, and the bit the taps predict for it.
  always_comb begin
    d_c        = din ^ inv;
    pred_c     = ^(hist_q & eqn);
    mismatch_c = d_c ^ pred_c;
  end

  // History always takes the received bit so the lane resynchronizes after errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
    end else if (shift) begin
      hist_q <= {hist_q[PRBS_W-2:0], d_c};
    end
  end

endmodule

// File: rtl/prbs_checker_rx16.sv
// Multi-lane PRBS checker: seed/hunt/lock FSM with error and cycle accumulators.
module prbs_checker_rx16
  import prbs_chk_pkg::*;
#(
  parameter int unsigned N_LANES  = 16,
  parameter int unsigned PRBS_W   = 32,
  parameter int unsigned LOCK_CYC = 64,
  parameter int unsigned LOSS_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr_cnt,
  input  logic [PRBS_W-1:0]  eqn,
  input  logic               inv,
  input  logic               din_valid,
  input  logic [N_LANES-1:0] din,
  output logic [STATE_W-1:0] state,
  output logic               locked,
  output logic [N_LANES-1:0] err_flag,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   cyc_cnt
);

  localparam int unsigned RUN_MAX = (PRBS_W > LOCK_CYC)
                                    ? ((PRBS_W > LOSS_CYC) ? PRBS_W : LOSS_CYC)
                                    : ((LOCK_CYC > LOSS_CYC) ? LOCK_CYC : LOSS_CYC);
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
  localparam int unsigned POP_W   = $clog2(N_LANES + 1);
  localparam int unsigned SUM_W   = CNT_W + 1;

  state_e             state_q;
  state_e             state_d;
  logic [RUN_W-1:0]   run_q;
  logic [RUN_W-1:0]   run_d;
  logic [N_LANES-1:0] mis_c;
  logic               any_mis_c;
  logic               hist_clr_c;
  logic               acc_en_c;
  logic [POP_W-1:0]   pop_c;
  logic [SUM_W-1:0]   err_sum_c;

  assign state      = state_q;
  assign any_mis_c  = |mis_c;
  assign hist_clr_c = ~en | (state_q == ST_IDLE);
  assign acc_en_c   = en & din_valid & (state_q == ST_LOCKED);

  // One checker per lane; histories are flushed while disabled or idle.
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    prbs_lane_checker #(
      .PRBS_W (PRBS_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .clr        (hist_clr_c),
      .shift      (din_valid),
      .inv        (inv),
      .eqn        (eqn),
      .din        (din[i]),
      .mismatch_c (mis_c[i])
    );
  end

  // Number of errored lanes this cycle and the unsaturated accumulator sum.
  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      pop_c = pop_c + POP_W'(mis_c[i]);
    end
    err_sum_c = {1'b0, err_cnt} + SUM_W'(pop_c);
  end

  // State and shared run counter (seed fill, good run, or bad run).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic; only valid samples advance the run counter.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (!en) begin
      state_d = ST_IDLE;
      run_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SEED;
          run_d   = '0;
        end
        ST_SEED: begin
          if (din_valid) begin
            if (run_q == RUN_W'(PRBS_W - 1)) begin
              state_d = ST_HUNT;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end
        end
        ST_HUNT: begin
          if (din_valid) begin
            if (any_mis_c) begin
              run_d = '0;
            end else if (run_q == RUN_W'(LOCK_CYC - 1)) begin
              state_d = ST_LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (din_valid) begin
            if (!any_mis_c) begin
              run_d = '0;
            end else if (run_q == RUN_W'(LOSS_CYC - 1)) begin
              state_d = ST_SEED;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  // Lock indicator tracks the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
    end else begin
      locked <= (state_d == ST_LOCKED);
    end
  end

  // Per-lane error flags: suppressed while seeding, held across invalid cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag <= '0;
    end else if (hist_clr_c) begin
      err_flag <= '0;
    end else if (din_valid) begin
      err_flag <= ((state_q == ST_HUNT) || (state_q == ST_LOCKED)) ? mis_c : '0;
    end
  end

  // Saturating accumulators, active only while locked; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      cyc_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
      cyc_cnt <= '0;
    end else if (acc_en_c) begin
      err_cnt <= err_sum_c[CNT_W] ? CNT_MAX : err_sum_c[CNT_W-1:0];
      cyc_cnt <= (cyc_cnt == CNT_MAX) ? CNT_MAX : cyc_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_prbs_checker_rx16.sv
// Randomized bench for prbs_checker_rx16 against a queue-based behavioural model.
module tb_prbs_checker_rx16;
  import prbs_chk_pkg::*;

  localparam int N    = 16;
  localparam int W    = 32;
  localparam int LOCK = 64;
  localparam int LOSS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          clr_cnt;
  logic [W-1:0]  eqn;
  logic          inv;
  logic          din_valid;
  logic [N-1:0]  din;
  logic [1:0]    state;
  logic          locked;
  logic [N-1:0]  err_flag;
  logic [31:0]   err_cnt;
  logic [31:0]   cyc_cnt;

  prbs_checker_rx16 #(
    .N_LANES  (N),
    .PRBS_W   (W),
    .LOCK_CYC (LOCK),
    .LOSS_CYC (LOSS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr_cnt   (clr_cnt),
    .eqn       (eqn),
    .inv       (inv),
    .din_valid (din_valid),
    .din       (din),
    .state     (state),
    .locked    (locked),
    .err_flag  (err_flag),
    .err_cnt   (err_cnt),
    .cyc_cnt   (cyc_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transmit-side sequence per lane (newest bit at index 0).
  bit          tx_q[N][$];
  logic [31:0] tx_eqn;

  // Reference model: received bits per lane (newest first) plus plain counters.
  bit           rx_q[N][$];
  int           m_state;
  int           m_run;
  logic [N-1:0] m_flag;
  longint       m_err;
  longint       m_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void tx_init();
    for (int i = 0; i < N; i++) begin
      tx_q[i].delete();
      for (int k = 0; k < W; k++) tx_q[i].push_back(1'($urandom_range(0, 1)));
      tx_q[i][0] = 1'b1;
    end
  endfunction

  function automatic logic [N-1:0] tx_next();
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      bit nb;
      nb = 1'b0;
      for (int k = 0; k < W; k++) if (tx_eqn[k]) nb ^= tx_q[i][k];
      tx_q[i].push_front(nb);
      void'(tx_q[i].pop_back());
      w[i] = nb;
    end
    return w;
  endfunction

  function automatic bit predict(input int ln);
    bit p;
    p = 1'b0;
    for (int k = 0; k < W; k++)
      if (eqn[k] && k < rx_q[ln].size()) p ^= rx_q[ln][k];
    return p;
  endfunction

  function automatic void model_clear_hist();
    for (int i = 0; i < N; i++) rx_q[i].delete();
  endfunction

  function automatic void model_reset();
    model_clear_hist();
    m_state = 0;
    m_run   = 0;
    m_flag  = '0;
    m_err   = 0;
    m_cyc   = 0;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT sees.
  function automatic void model_step();
    logic [N-1:0] mis;
    bit           d;
    mis = '0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!en) begin
      model_clear_hist();
      m_state = 0;
      m_run   = 0;
      m_flag  = '0;
    end else if (m_state == 0) begin
      model_clear_hist();
      m_state = 1;
      m_run   = 0;
      m_flag  = '0;
    end else if (din_valid) begin
      for (int i = 0; i < N; i++) begin
        d      = din[i] ^ inv;
        mis[i] = d ^ predict(i);
        rx_q[i].push_front(d);
        if (rx_q[i].size() > W) void'(rx_q[i].pop_back());
      end
      case (m_state)
        1: begin
          m_flag = '0;
          m_run++;
          if (m_run == W) begin m_state = 2; m_run = 0; end
        end
        2: begin
          m_flag = mis;
          if (mis != 0) m_run = 0;
          else begin
            m_run++;
            if (m_run == LOCK) begin m_state = 3; m_run = 0; end
          end
        end
        default: begin
          m_flag = mis;
          m_err  = m_err + $countones(mis);
          if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
          if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
          if (mis == 0) m_run = 0;
          else begin
            m_run++;
            if (m_run == LOSS) begin m_state = 1; m_run = 0; end
          end
        end
      endcase
    end
    if (clr_cnt) begin
      m_err = 0;
      m_cyc = 0;
    end
  endfunction

  task automatic compare_all();
    check("state", 32'(state), 32'(m_state));
    check("locked", 32'(locked), 32'(m_state == 3));
    check("err_flag", 32'(err_flag), 32'(m_flag));
    check("err_cnt", err_cnt, 32'(m_err));
    check("cyc_cnt", cyc_cnt, 32'(m_cyc));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit valid, input logic [N-1:0] flip, input bit rnd, input bit neg);
    din_valid = valid;
    if (!valid || rnd) din = N'($urandom);
    else               din = tx_next() ^ flip ^ (neg ? {N{1'b1}} : {N{1'b0}});
  endtask

  // Run from the enabling edge until lock; report cycles (or valid samples with gaps).
  task automatic wait_lock(input string tag, input int exp, input bit gaps, input bit neg);
    int first;
    int nval;
    first = 0;
    nval  = 0;
    for (int c = 1; c <= 400 && first == 0; c++) begin
      bit v;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      drive(v, '0, 1'b0, neg);
      if (c > 1 && v) nval++;
      tick();
      if (locked) first = gaps ? nval : c;
    end
    check(tag, 32'(first), 32'(exp));
  endtask

  initial begin
    int first;
    rst       = 1'b1;
    en        = 1'b0;
    clr_cnt   = 1'b0;
    eqn       = DEFAULT_EQN;
    tx_eqn    = 32'h0010_0002;
    inv       = 1'b0;
    din_valid = 1'b0;
    din       = '0;
    tx_init();
    model_reset();

    // Reset values.
    repeat (2) tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_cnt", err_cnt, 32'd0);
    rst = 1'b0;

    // Clean lock: 32 seed + 64 good + the enabling cycle.
    en = 1'b1;
    wait_lock("lock_lat", 97, 1'b0, 1'b0);
    check("lock_err_cnt", err_cnt, 32'd0);
    repeat (20) begin drive(1'b1, '0, 1'b0, 1'b0); tick(); end

    // Single error on lane 5 propagates through both taps.
    clr_cnt = 1'b1;
    drive(1'b1, '0, 1'b0, 1'b0); tick();
    clr_cnt = 1'b0;
    drive(1'b1, 16'h0020, 1'b0, 1'b0); tick();
    check("err_flag5", 32'(err_flag), 32'h0000_0020);
    repeat (25) begin drive(1'b1, '0, 1'b0, 1'b0); tick(); end
    check("single_err_cnt", err_cnt, 32'd3);
    check("single_locked", 32'(locked), 32'd1);

    // Clear concurrent with an injected error.
    clr_cnt = 1'b1;
    drive(1'b1, 16'h0100, 1'b0, 1'b0); tick();
    check("clr_wins", err_cnt, 32'd0);
    clr_cnt = 1'b0;
    repeat (30) begin drive(1'b1, '0, 1'b0, 1'b0); tick(); end

    // Asynchronous reset pulse mid-lock, away from the clock edge.
    drive(1'b1, '0, 1'b0, 1'b0);
    @(posedge clk);
    model_step();
    #3 rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_flag", 32'(err_flag), 32'd0);
    check("arst_err_cnt", err_cnt, 32'd0);
    check("arst_cyc_cnt", cyc_cnt, 32'd0);
    model_reset();
    #2 rst = 1'b0;
    wait_lock("relock_lat", 97, 1'b0, 1'b0);

    // Loss of lock on random data.
    first = 0;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      drive(1'b1, '0, 1'b1, 1'b0);
      tick();
      if (state == 2'd1) first = c;
    end
    check("loss_cycles", 32'(first), 32'd16);
    check("loss_locked", 32'(locked), 32'd0);

    // Polarity: inverted line with inv=1 locks normally.
    en = 1'b0;
    drive(1'b1, '0, 1'b0, 1'b1); tick();
    en  = 1'b1;
    inv = 1'b1;
    wait_lock("inv_lock_lat", 97, 1'b0, 1'b1);

    // Inverted line without correction never locks.
    en = 1'b0;
    drive(1'b1, '0, 1'b0, 1'b1); tick();
    en  = 1'b1;
    inv = 1'b0;
    repeat (200) begin drive(1'b1, '0, 1'b0, 1'b1); tick(); end
    check("noinv_state", 32'(state), 32'd2);
    check("noinv_locked", 32'(locked), 32'd0);

    // Gapped input: lock after 96 valid samples.
    en = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    en = 1'b1;
    wait_lock("gap_lock_samples", 96, 1'b1, 1'b0);
    repeat (40) begin drive(1'($urandom_range(0, 1)), '0, 1'b0, 1'b0); tick(); end
    check("gap_locked", 32'(locked), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
